uart_tx_scheduler: RTL



---
 rtl/uart_tx_scheduler.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//
// Queues bytes that the pipeline stores to the UART address. It then feeds
// them to a UART transmitter that has no busy flag. Because the transmitter
// cannot report when it is done, a fixed frame time is counted between write
// strobes. Bytes leave in the order they arrived.
//
// Ports:
//   clk        system clock, rising edge
//   rstd       synchronous active-low reset
//   wr_valid   pipeline store to the UART address this cycle
//   wr_data    byte to transmit
//   full       FIFO holds DEPTH bytes; the pipeline must stall UART stores
//   count      bytes currently queued, 0..DEPTH
//   overflow   sticky until reset: a store arrived while the FIFO was full
//   idle       FIFO empty and no frame in flight
//   uart_we    one-cycle write strobe to the transmitter
//   uart_data  byte presented to the transmitter, held between pops
//
// States:
//   ST_IDLE | no frame on the wire; pop as soon as a byte is queued
//   ST_WAIT | frame in flight; frame counter runs down to zero before next pop

module uart_tx_scheduler #(
  parameter int DEPTH        = 16,
  parameter int FRAME_CYCLES = 8680
) (
  input  logic                   clk,
  input  logic                   rstd,
  input  logic                   wr_valid,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   idle,
  output logic                   uart_we,
  output logic [7:0]             uart_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(FRAME_CYCLES);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [CW-1:0] FRAME_RELOAD = CW'(FRAME_CYCLES - 1);
  localparam logic [PW-1:0] DEPTH_CNT    = PW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          idle_q, idle_d;
  logic          overflow_q, overflow_d;
  logic          uart_we_q, uart_we_d;
  logic [7:0]    uart_data_q, uart_data_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic [0:0]    state_q, state_d;

  logic empty;
  logic push;
  logic pop;
  logic frame_done;

  assign empty      = (count_q == '0);
  assign push       = wr_valid && !full_q;
  assign frame_done = (frame_cnt_q == '0);
  // The counter only runs in WAIT and always reaches zero before leaving
  // it, so in IDLE frame_done is true and any queued byte pops immediately.
  assign pop        = !empty && ((state_q == ST_IDLE) || frame_done);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    uart_data_d = uart_data_q;
    uart_we_d   = 1'b0;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PW'(1);
      uart_we_d   = 1'b1;
      uart_data_d = mem_q[rd_ptr_q[AW-1:0]];
      frame_cnt_d = FRAME_RELOAD;
      state_d     = ST_WAIT;
    end else if (!frame_done) begin
      frame_cnt_d = frame_cnt_q - CW'(1);
    end else if (state_q == ST_WAIT) begin
      state_d = ST_IDLE;
    end

    // Pointers carry one extra wrap bit, so their difference is the fill
    // level over the full 0..DEPTH range.
    count_d    = wr_ptr_d - rd_ptr_d;
    full_d     = (count_d == DEPTH_CNT);
    idle_d     = (count_d == '0) && (state_d == ST_IDLE);
    overflow_d = overflow_q || (wr_valid && full_q);
  end

  always_ff @(posedge clk) begin
    if (!rstd) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      idle_q      <= 1'b1;
      overflow_q  <= 1'b0;
      uart_we_q   <= 1'b0;
      uart_data_q <= 8'h00;
      frame_cnt_q <= '0;
      state_q     <= ST_IDLE;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      idle_q      <= idle_d;
      overflow_q  <= overflow_d;
      uart_we_q   <= uart_we_d;
      uart_data_q <= uart_data_d;
      frame_cnt_q <= frame_cnt_d;
      state_q     <= state_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (rstd && push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  assign full      = full_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign idle      = idle_q;
  assign uart_we   = uart_we_q;
  assign uart_data = uart_data_q;

endmodule
